solver_arb: RTL
===============

# solver_arb

Round-robin arbiter and sequencer that shares one `Solver` instance (6x6 LDLᵀ forward/backward substitution) between two requesters, e.g. the coarse-level and fine-level pose-update loops.
- Registers the granted request's operands and issues a one-cycle start to `Solver`.
- Watches completion with a watchdog and returns the solution plus error flags to the owning requester over a valid/ready response channel.
- Sits between the normal-equation accumulators and `Solver` in the VO top level.

## Interface
- `TIMEOUT_CYC`, default 255: cycles in WAIT without `i_slv_done` before a timeout is declared; legal range 120..255.
- `MATRIX_BW`, from `RgbdVoConfigPk`: operand word width; not overridable here.
- `i_clk` in 1: single clock.
- `i_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_req0_valid` / `i_req1_valid` in 1: request present.
- `o_req0_ready` / `o_req1_ready` out 1: request accepted when valid&ready.
- `i_req0_mat` / `i_req1_mat` in 21*MATRIX_BW: lower-triangle words.
  - Word k at bits [k*MATRIX_BW +: MATRIX_BW].
  - Order 00,10,20,30,40,50,11,21,31,41,51,22,32,42,52,33,43,53,44,54,55.
- `i_req0_vec` / `i_req1_vec` in 6*MATRIX_BW: RHS vector, word k is element k.
- `o_rsp0_valid` / `o_rsp1_valid` out 1: solution available for that requester.
- `i_rsp0_ready` / `i_rsp1_ready` in 1: response consumed.
- `o_rsp_x` out 6*MATRIX_BW: solution, shared by both response channels.
- `o_rsp_err` out 2: bit0 = div_zero, bit1 = timeout.
- `o_slv_start` out 1: start pulse to `Solver`.
- `o_slv_mat` out 21*MATRIX_BW: registered operands to `Solver`.
- `o_slv_vec` out 6*MATRIX_BW: registered operands to `Solver`.
- `i_slv_done` in 1: `Solver` done pulse.
- `i_slv_div_zero` in 1: `Solver` divide-by-zero flag.
- `i_slv_x` in 6*MATRIX_BW: `Solver` X0..X5.
- `o_busy` out 1: state ≠ IDLE.
- `o_timeout_cnt` out 8: saturating count of timeouts.

## Operation
- States: IDLE, START, WAIT, RESP, DRAIN.
- IDLE:
  - grant = rr_ptr if that requester is valid, else the other valid requester.
  - `o_reqN_ready` = (state==IDLE) && grant==N. Ready may depend on valid; valid must never depend on ready.
  - On handshake: capture mat/vec into operand registers, record owner, set rr_ptr = ~owner, go to START.
- START: `o_slv_start`=1 for exactly this cycle; operand registers are stable; go to WAIT and clear the watchdog.
- WAIT: the watchdog increments each cycle.
  - On `i_slv_done`: capture `i_slv_x` into `o_rsp_x`, set err = {0, `i_slv_div_zero`}, go to RESP.
  - If the watchdog reaches TIMEOUT_CYC first: `o_rsp_x`=0, err=2'b10, increment `o_timeout_cnt` (saturating at 255), go to RESP.
  - `i_slv_done` takes precedence over a same-cycle timeout.
- RESP:
  - `o_rspN_valid`=1 for the owner only; x and err are held stable until the owner's ready.
  - On handshake: go to DRAIN if the transaction timed out, else to IDLE.
- DRAIN:
  - Waits for a late `i_slv_done` (ignored, nothing captured) or a further TIMEOUT_CYC cycles, whichever comes first, then goes to IDLE.
  - This prevents a new start landing while `Solver` is still busy.
- `i_slv_done` outside WAIT/DRAIN is ignored.
- Operand registers hold their value outside START, so `o_slv_mat`/`o_slv_vec` are always registered and glitch-free.
- Arithmetic: none. Operands and results pass through unmodified in signed fixed point (`MUL` fraction bits per `RgbdVoConfigPk`).

## Timing
- Reset values:
  - state IDLE, rr_ptr 0.
  - All ready/valid/start outputs 0.
  - `o_rsp_x`, `o_rsp_err`, `o_slv_mat`, `o_slv_vec` 0.
  - `o_timeout_cnt` 0, `o_busy` 0.
- Request handshake at cycle T: `o_slv_start` at T+1, `o_busy` from T+1.
- `Solver` nominal latency is ~111 cycles from start to done. The arbiter must not depend on the exact value.
- Done at cycle D: `o_rspN_valid` from D+1.
- Response handshake at cycle R: IDLE at R+1, next grant possible at R+1.
- Minimum spacing between two starts: solver latency + 3 cycles.
- Reset asserted mid-operation returns everything to reset values asynchronously. `Solver` shares the same reset, so no drain is needed.

## Structure
- Add to `RgbdVoConfigPk`:
  - `SOLVER_MAT_WORDS`=21, `SOLVER_VEC_WORDS`=6.
  - `solver_arb_state_e` enum.
  - Err bit index constants `SLV_ERR_DZ`=0, `SLV_ERR_TO`=1.
- No sub-module. `Solver` is instantiated alongside at the top level, not inside this block.

## Test plan
- Single request: req0 with D=1.0 (1<<MUL), L=0, vec={1,2,3,4,5,6} (Q format), behavioural `Solver`.
  - Required: one start pulse; rsp0_valid with x=vec and err=00; rsp1_valid never asserts.
- Both valid from reset:
  - Required: req0 granted first, then req1; alternating grants over 4 back-to-back pairs.
- Response back-pressure: hold rsp0_ready=0 for 50 cycles.
  - Required: x/err stable, no new grant, req1_ready=0 throughout.
- Division by zero: `Solver` model returns div_zero=1.
  - Required: err=01, x passed through, state → IDLE after the handshake.
- Timeout: `Solver` model never raises done.
  - Required: rsp err=10 and x=0 exactly TIMEOUT_CYC cycles after the start cycle.
  - `o_timeout_cnt`=1.
  - DRAIN lasts a further 255 cycles, or ends on an injected late done; no start issued during DRAIN.
- Reset mid-WAIT (cycle 60 after start):
  - Required: all outputs at reset values immediately.
  - A fresh request after reset completes normally.

Source files
------------

// File: rtl/rgbd_vo_config_pk.sv
// Shared VO configuration: operand widths, fixed-point format and the
// solver arbiter's state and error encodings.
package RgbdVoConfigPk;

    localparam int MATRIX_BW        = 32;
    localparam int MUL              = 16;

    localparam int SOLVER_MAT_WORDS = 21;
    localparam int SOLVER_VEC_WORDS = 6;
    localparam int SOLVER_MAT_W     = SOLVER_MAT_WORDS * MATRIX_BW;
    localparam int SOLVER_VEC_W     = SOLVER_VEC_WORDS * MATRIX_BW;

    localparam int SLV_ERR_DZ       = 0;
    localparam int SLV_ERR_TO       = 1;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_START,
        ARB_WAIT,
        ARB_RESP,
        ARB_DRAIN
    } solver_arb_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/solver_arb.sv
// Round-robin arbiter sharing one Solver between two requesters, with a
// completion watchdog and a drain phase after a timed-out solve.
module solver_arb
    import RgbdVoConfigPk::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req0_valid,
    output logic                    o_req0_ready,
    input  logic [SOLVER_MAT_W-1:0] i_req0_mat,
    input  logic [SOLVER_VEC_W-1:0] i_req0_vec,
    input  logic                    i_req1_valid,
    output logic                    o_req1_ready,
    input  logic [SOLVER_MAT_W-1:0] i_req1_mat,
    input  logic [SOLVER_VEC_W-1:0] i_req1_vec,
    output logic                    o_rsp0_valid,
    input  logic                    i_rsp0_ready,
    output logic                    o_rsp1_valid,
    input  logic                    i_rsp1_ready,
    output logic [SOLVER_VEC_W-1:0] o_rsp_x,
    output logic [1:0]              o_rsp_err,
    output logic                    o_slv_start,
    output logic [SOLVER_MAT_W-1:0] o_slv_mat,
    output logic [SOLVER_VEC_W-1:0] o_slv_vec,
    input  logic                    i_slv_done,
    input  logic                    i_slv_div_zero,
    input  logic [SOLVER_VEC_W-1:0] i_slv_x,
    output logic                    o_busy,
    output logic [7:0]              o_timeout_cnt
);

    // wdog holds cycles elapsed since the start cycle, so a timeout response
    // appears exactly TIMEOUT_CYC cycles after start.
    localparam logic [7:0] WAIT_LIMIT  = 8'(TIMEOUT_CYC - 1);
    localparam logic [7:0] DRAIN_LIMIT = 8'(TIMEOUT_CYC);

    solver_arb_state_e state, state_nxt;

    logic       rr_ptr;
    logic       owner;
    logic       timed_out;
    logic [7:0] wdog;
    logic       grant;
    logic       req_take;
    logic       wait_done;
    logic       wait_to;
    logic       rsp_take;
    logic [1:0] err_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ARB_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = rr_ptr;
        req_take  = 1'b0;
        wait_done = 1'b0;
        wait_to   = 1'b0;
        rsp_take  = 1'b0;
        err_nxt   = '0;
        case (state)
            ARB_IDLE: begin
                if (rr_ptr ? !i_req1_valid : !i_req0_valid) grant = ~rr_ptr;
                req_take = grant ? i_req1_valid : i_req0_valid;
                if (req_take) state_nxt = ARB_START;
            end
            ARB_START: state_nxt = ARB_WAIT;
            ARB_WAIT: begin
                // A done in the same cycle as the timeout wins.
                wait_done = i_slv_done;
                wait_to   = !i_slv_done && (wdog == WAIT_LIMIT);
                if (wait_done) err_nxt[SLV_ERR_DZ] = i_slv_div_zero;
                if (wait_to)   err_nxt[SLV_ERR_TO] = 1'b1;
                if (wait_done || wait_to) state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                rsp_take = owner ? i_rsp1_ready : i_rsp0_ready;
                if (rsp_take) state_nxt = timed_out ? ARB_DRAIN : ARB_IDLE;
            end
            ARB_DRAIN: begin
                if (i_slv_done || (wdog == DRAIN_LIMIT)) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign o_req0_ready = req_take && !grant;
    assign o_req1_ready = req_take && grant;
    assign o_rsp0_valid = (state == ARB_RESP) && !owner;
    assign o_rsp1_valid = (state == ARB_RESP) && owner;
    assign o_slv_start  = (state == ARB_START);
    assign o_busy       = (state != ARB_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr        <= 1'b0;
            owner         <= 1'b0;
            timed_out     <= 1'b0;
            wdog          <= '0;
            o_slv_mat     <= '0;
            o_slv_vec     <= '0;
            o_rsp_x       <= '0;
            o_rsp_err     <= '0;
            o_timeout_cnt <= '0;
        end else begin
            if (req_take) begin
                o_slv_mat <= grant ? i_req1_mat : i_req0_mat;
                o_slv_vec <= grant ? i_req1_vec : i_req0_vec;
                owner     <= grant;
                rr_ptr    <= ~grant;
            end
            if ((state == ARB_START) || rsp_take)
                wdog <= 8'd1;
            else if ((state == ARB_WAIT) || (state == ARB_DRAIN))
                wdog <= wdog + 8'd1;
            if (wait_done) begin
                o_rsp_x   <= i_slv_x;
                o_rsp_err <= err_nxt;
                timed_out <= 1'b0;
            end
            if (wait_to) begin
                o_rsp_x       <= '0;
                o_rsp_err     <= err_nxt;
                timed_out     <= 1'b1;
                o_timeout_cnt <= sat_inc8(o_timeout_cnt);
            end
        end
    end

endmodule
